// File: rtl/issue_dispatch_queue.sv
// Instruction queue between the fetcher and ROB/RS/LSB: decodes the head entry,
// resolves its operands from the register file or the CDB, and dispatches one per cycle.
module issue_dispatch_queue #(
   parameter int DEPTH = 8,
   parameter int ROB_W = 4,
   parameter int NCDB  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    flush,
   input  logic                    if_valid,
   output logic                    if_ready,
   input  logic [31:0]             if_ins,
   input  logic [31:0]             if_pc,
   input  logic                    if_pred_taken,
   input  logic [31:0]             if_pred_pc,
   input  logic                    rob_full,
   input  logic                    rs_full,
   input  logic                    lsb_full,
   input  logic [ROB_W-1:0]        rob_name,
   output logic [4:0]              reg_rs1,
   output logic [4:0]              reg_rs2,
   input  logic [31:0]             reg_rs1_val,
   input  logic [31:0]             reg_rs2_val,
   input  logic                    reg_rs1_rdy,
   input  logic                    reg_rs2_rdy,
   input  logic [NCDB-1:0]         cdb_valid,
   input  logic [NCDB*ROB_W-1:0]   cdb_tag,
   input  logic [NCDB*32-1:0]      cdb_result,
   output logic                    dsp_valid,
   output logic                    dsp_to_rs,
   output logic                    dsp_to_lsb,
   output logic                    dsp_to_reg,
   output logic [31:0]             dsp_ins,
   output logic [31:0]             dsp_pc,
   output logic [31:0]             dsp_pred_pc,
   output logic                    dsp_pred_taken,
   output logic [31:0]             dsp_imm,
   output logic [4:0]              dsp_rd,
   output logic [ROB_W-1:0]        dsp_tag,
   output logic [31:0]             dsp_rs1_val,
   output logic [31:0]             dsp_rs2_val,
   output logic                    dsp_rs1_rdy,
   output logic                    dsp_rs2_rdy
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic        pred_taken;
      logic [31:0] pred_pc;
   } ent_t;

   typedef struct packed {
      logic             valid, to_rs, to_lsb, to_reg;
      logic [31:0]      ins, pc, pred_pc;
      logic             pred_taken;
      logic [31:0]      imm;
      logic [4:0]       rd;
      logic [ROB_W-1:0] tag;
      logic [31:0]      rs1_val, rs2_val;
      logic             rs1_rdy, rs2_rdy;
   } dsp_t;

   ent_t            mem_q [DEPTH];
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [PW:0]     count_q, count_d;
   dsp_t            dsp_q, dsp_d;

   ent_t        head;
   logic [31:0] imm;
   logic        known, need_rs, need_lsb, to_reg, zero_ops, rs2_imm, shift;
   logic        can_go, pop, push, dispatch;
   logic [32:0] res1, res2, op1, op2;

   // Lowest-index matching channel wins; a ready register value beats any broadcast.
   function automatic logic [32:0] resolve(input logic [31:0] val, input logic ready,
                                           input logic [NCDB-1:0] cv,
                                           input logic [NCDB*ROB_W-1:0] ct,
                                           input logic [NCDB*32-1:0] cr);
      logic [32:0] r;
      r = {1'b0, {(32-ROB_W){1'b0}}, val[ROB_W-1:0]};
      for (int i = NCDB-1; i >= 0; i--)
         if (cv[i] && ct[i*ROB_W +: ROB_W] == val[ROB_W-1:0]) r = {1'b1, cr[i*32 +: 32]};
      if (ready) r = {1'b1, val};
      return r;
   endfunction

   assign head    = mem_q[head_q];
   assign reg_rs1 = head.ins[19:15];
   assign reg_rs2 = head.ins[24:20];

   always_comb begin
      known = 1'b1; need_rs = 1'b0; need_lsb = 1'b0; to_reg = 1'b1;
      zero_ops = 1'b0; rs2_imm = 1'b0; imm = '0;
      case (head.ins[6:0])
         7'b0110111, 7'b0010111: begin
            imm = {head.ins[31:12], 12'b0}; zero_ops = 1'b1;
         end
         7'b1101111: begin
            imm = {{12{head.ins[31]}}, head.ins[19:12], head.ins[20], head.ins[30:21], 1'b0};
            zero_ops = 1'b1;
         end
         7'b1100111, 7'b0010011: begin
            need_rs = 1'b1; rs2_imm = 1'b1; imm = {{21{head.ins[31]}}, head.ins[30:20]};
         end
         7'b0000011: begin
            need_rs = 1'b1; need_lsb = 1'b1; rs2_imm = 1'b1;
            imm = {{21{head.ins[31]}}, head.ins[30:20]};
         end
         7'b1100011: begin
            need_rs = 1'b1; to_reg = 1'b0;
            imm = {{20{head.ins[31]}}, head.ins[7], head.ins[30:25], head.ins[11:8], 1'b0};
         end
         7'b0100011: begin
            need_rs = 1'b1; need_lsb = 1'b1; to_reg = 1'b0;
            imm = {{21{head.ins[31]}}, head.ins[30:25], head.ins[11:7]};
         end
         7'b0110011: need_rs = 1'b1;
         default: begin known = 1'b0; to_reg = 1'b0; end
      endcase
      shift = (head.ins[6:0] == 7'b0010011) && (head.ins[13:12] == 2'b01);
   end

   always_comb begin
      res1 = resolve(reg_rs1_val, reg_rs1_rdy, cdb_valid, cdb_tag, cdb_result);
      res2 = resolve(reg_rs2_val, reg_rs2_rdy, cdb_valid, cdb_tag, cdb_result);
      op1  = zero_ops ? {1'b1, 32'b0} : res1;
      if (zero_ops)     op2 = {1'b1, 32'b0};
      else if (shift)   op2 = {1'b1, 27'b0, head.ins[24:20]};
      else if (rs2_imm) op2 = {1'b1, imm};
      else              op2 = res2;
   end

   // if_valid/if_ready: an instruction is taken at a rising edge where both are high,
   // rdy is high and flush is low; if_valid must not depend on if_ready.
   assign if_ready = !rst && (count_q != CNT_FULL);
   assign can_go   = (count_q != '0) && !flush && !rob_full &&
                     (!need_rs || !rs_full) && (!need_lsb || !lsb_full);
   assign pop      = rdy && (count_q != '0) && !flush && (!known || can_go);
   assign dispatch = rdy && known && can_go;
   assign push     = rdy && if_valid && if_ready && !flush;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rdy && flush) begin
         head_d = '0; tail_d = '0; count_d = '0;
      end else begin
         if (pop)  head_d = head_q + PW'(1);
         if (push) tail_d = tail_q + PW'(1);
         count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

   always_comb begin
      dsp_d = dsp_q;
      if (rdy) begin
         dsp_d.valid = 1'b0;
         if (dispatch) begin
            dsp_d.valid      = 1'b1;
            dsp_d.to_rs      = need_rs;
            dsp_d.to_lsb     = need_lsb;
            dsp_d.to_reg     = to_reg;
            dsp_d.ins        = head.ins;
            dsp_d.pc         = head.pc;
            dsp_d.pred_pc    = head.pred_pc;
            dsp_d.pred_taken = head.pred_taken;
            dsp_d.imm        = imm;
            dsp_d.rd         = head.ins[11:7];
            dsp_d.tag        = rob_name;
            dsp_d.rs1_rdy    = op1[32];
            dsp_d.rs1_val    = op1[31:0];
            dsp_d.rs2_rdy    = op2[32];
            dsp_d.rs2_val    = op2[31:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         dsp_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         dsp_q   <= dsp_d;
      end
   end

   // Payload storage needs no reset: entries are only read once counted valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= {if_ins, if_pc, if_pred_taken, if_pred_pc};
   end

   assign dsp_valid      = dsp_q.valid;
   assign dsp_to_rs      = dsp_q.to_rs;
   assign dsp_to_lsb     = dsp_q.to_lsb;
   assign dsp_to_reg     = dsp_q.to_reg;
   assign dsp_ins        = dsp_q.ins;
   assign dsp_pc         = dsp_q.pc;
   assign dsp_pred_pc    = dsp_q.pred_pc;
   assign dsp_pred_taken = dsp_q.pred_taken;
   assign dsp_imm        = dsp_q.imm;
   assign dsp_rd         = dsp_q.rd;
   assign dsp_tag        = dsp_q.tag;
   assign dsp_rs1_val    = dsp_q.rs1_val;
   assign dsp_rs2_val    = dsp_q.rs2_val;
   assign dsp_rs1_rdy    = dsp_q.rs1_rdy;
   assign dsp_rs2_rdy    = dsp_q.rs2_rdy;
endmodule
